mems_spi_slave: RTL
===================

// Module: mems_spi_slave
// PURPOSE
// - SPI responder for the 24-bit MEMS command link; models the driver-chip end of the frame (loopback/bring-up, HIL).
// - Sits on the system clock; oversamples async sck/cs/mosi, shifts out a queued 24-bit reply, captures the 24-bit command.
// - Protocol: CPOL=0, CS active-low, MSB first; master drives MOSI after SCK rise, samples MISO just before SCK fall.
// - Slave therefore samples MOSI on SCK fall and advances MISO after that fall.
// PARAMETERS
// - WIDTH        24      frame length in bits
// - SYNC_STAGES  2       flops in each sck/cs/mosi synchronizer (>=2)
// - IDLE_WORD    24'h0   word shifted out when no reply is queued at frame start
// PORTS
// - clk         in   1      system clock
// - rst         in   1      asynchronous reset, active-low
// - sck         in   1      SPI clock from master (async)
// - cs          in   1      chip select, active-low (async)
// - mosi        in   1      master-out data (async)
// - miso        out  1      slave-out data
// - miso_oe     out  1      MISO drive enable; 1 while frame active
// - tx_data     in   WIDTH  reply word to queue
// - tx_valid    in   1      tx_data valid; accepted when tx_valid & tx_ready
// - tx_ready    out  1      1 when holding register empty
// - rx_data     out  WIDTH  last complete command word
// - rx_valid    out  1      1-cycle pulse: rx_data updated
// - busy        out  1      1 when FSM not IDLE
// - frame_err   out  1      1-cycle pulse: CS rose before WIDTH bits
// - tx_underrun out  1      1-cycle pulse: frame started with empty holding register
// BEHAVIOUR
// - Reset (rst=0, async): state IDLE; miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid/frame_err/tx_underrun=0, busy=0, holding reg empty, bit ctr=0.
// - Inputs pass SYNC_STAGES-flop synchronizers; sync'd sck/cs delayed one more flop for edge detect; mosi sampled from its synced copy (same depth as sck).
// - Timing requirement: SCK high and low phases each >= SYNC_STAGES+2 clk; master at CLK_DIV>=3 on shared clk meets this.
// - Holding reg: tx_valid&tx_ready loads it, tx_ready drops next cycle; emptied when a frame start consumes it.
// - FSM IDLE: on synced cs fall -> SHIFT; load shifter from holding reg (or IDLE_WORD + tx_underrun pulse if empty); miso=shifter MSB, miso_oe=1, ctr=0.
// - SHIFT, sck fall: rx shifter <= {rx[WIDTH-2:0], mosi}; tx shifter shifts left (zero fill); miso=new MSB; ctr+1.
// - SHIFT, fall making ctr==WIDTH: rx_data <= completed word, rx_valid pulse same cycle as update; -> WAIT_CS.
// - WAIT_CS: further sck edges ignored, miso=0; on cs rise -> IDLE, miso_oe=0.
// - SHIFT, cs rise before WIDTH falls: frame_err pulse, rx_data unchanged, no rx_valid -> IDLE; reply word discarded.
// - sck rising edges ignored for data; sck edges while cs high ignored.
// - cs fall and tx_valid same cycle with empty holding reg: frame uses IDLE_WORD (underrun); new word stays queued for next frame.
// - cs rise and sck fall same sampled cycle: cs wins (abort if ctr<WIDTH-1).
// - Back-to-back frames: cs high for >= SYNC_STAGES+2 clk required; IDLE re-arms in 1 cycle.
// - Reset mid-frame: immediate return to reset values; frame restarts only on next cs fall.
// STRUCTURE
// - Shared package mems_spi_pkg: MEMS_SPI_WIDTH=24, state encoding (IDLE/SHIFT/WAIT_CS), IDLE_WORD default; reused by mems_spi_master.
// - One sub-module: mems_spi_sync (SYNC_STAGES synchronizer + registered rise/fall pulses), instanced for sck and cs; mosi uses sync only.
// - Top holds holding reg, tx/rx shifters, 5-bit ctr, FSM.
// TESTING
// - Queue tx 24'hA5C3F0, master sends 24'h123456 -> master reads 24'hA5C3F0; rx_data=24'h123456 with one rx_valid pulse; tx_ready back to 1.
// - No tx queued, frame of 24'hFFFFFF -> tx_underrun pulse at cs fall, master reads IDLE_WORD 24'h000000, rx_data=24'hFFFFFF.
// - cs raised after 10 sck falls -> frame_err pulse, no rx_valid, rx_data keeps previous value, busy=0 after cs rise sync.
// - 26 sck clocks in one frame, tx 24'h800001 -> rx_valid after 24th fall; miso=0 for bits 25-26; rx_data = first 24 bits.
// - rst asserted mid-frame at bit 12 -> all outputs at reset values same cycle; after release, next full frame of 24'h00FF00 received correctly.
// - Back-to-back frames with minimum cs-high gap, replies 24'h111111 then 24'h222222 (second queued during first) -> both returned in order, two rx_valid pulses.

Source files
------------

// File: rtl/mems_spi_pkg.sv
// rtl/mems_spi_pkg.sv - shared constants and FSM encoding for the MEMS SPI link
// Reused by both ends of the 24-bit command link.
package mems_spi_pkg;

   localparam int MEMS_SPI_WIDTH = 24;
   localparam logic [MEMS_SPI_WIDTH-1:0] MEMS_SPI_IDLE_WORD = '0;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SHIFT   = 2'd1,
      ST_WAIT_CS = 2'd2
   } spi_state_e;

endpackage

// File: rtl/mems_spi_slave_if.sv
// rtl/mems_spi_slave_if.sv - SPI pins plus reply/command handshake of the MEMS SPI responder
// The slave modport is the responder view; master is the bench/driver view.
interface mems_spi_slave_if
   import mems_spi_pkg::*;
#(
   parameter int WIDTH = MEMS_SPI_WIDTH
);
   logic             sck;
   logic             cs;
   logic             mosi;
   logic             miso;
   logic             miso_oe;
   logic [WIDTH-1:0] tx_data;
   logic             tx_valid;
   logic             tx_ready;
   logic [WIDTH-1:0] rx_data;
   logic             rx_valid;
   logic             busy;
   logic             frame_err;
   logic             tx_underrun;

   modport slave (
      input  sck, cs, mosi, tx_data, tx_valid,
      output miso, miso_oe, tx_ready, rx_data, rx_valid, busy, frame_err, tx_underrun
   );

   modport master (
      output sck, cs, mosi, tx_data, tx_valid,
      input  miso, miso_oe, tx_ready, rx_data, rx_valid, busy, frame_err, tx_underrun
   );
endinterface

// File: rtl/mems_spi_sync.sv
// rtl/mems_spi_sync.sv - multi-flop synchronizer with edge pulses for an async SPI pin
// Edge pulses compare the synchronized level against one extra delay flop.
module mems_spi_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_q,
   output logic o_rise,
   output logic o_fall
);
   logic [STAGES-1:0] r_sync;
   logic              r_dly;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync <= {STAGES{RST_VAL}};
         r_dly  <= RST_VAL;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_d};
         r_dly  <= r_sync[STAGES-1];
      end
   end

   assign o_q    = r_sync[STAGES-1];
   assign o_rise = r_sync[STAGES-1] & ~r_dly;
   assign o_fall = ~r_sync[STAGES-1] & r_dly;
endmodule

// File: rtl/mems_spi_slave.sv
// rtl/mems_spi_slave.sv - oversampling SPI responder for the 24-bit MEMS command link
// CPOL=0, CS active-low, MSB first; MOSI sampled and MISO advanced on SCK fall.
module mems_spi_slave
   import mems_spi_pkg::*;
#(
   parameter int               WIDTH       = MEMS_SPI_WIDTH,
   parameter int               SYNC_STAGES = 2,
   parameter logic [WIDTH-1:0] IDLE_WORD   = MEMS_SPI_IDLE_WORD
) (
   input  logic              clk,
   input  logic              rst,
   mems_spi_slave_if.slave   bus
);
   localparam int CTR_W = $clog2(WIDTH + 1);

   spi_state_e              r_state, w_state_nxt;
   logic [WIDTH-1:0]        r_hold, r_tx_sh, r_rx_sh, r_rx_data;
   logic                    r_hold_full, r_miso, r_miso_oe;
   logic                    r_rx_valid, r_frame_err, r_underrun;
   logic [CTR_W-1:0]        r_ctr;
   logic [SYNC_STAGES-1:0]  r_mosi_sync;

   logic w_sck_q, w_sck_rise, w_sck_fall, w_cs_q, w_cs_rise, w_cs_fall;
   logic w_start, w_shift, w_done, w_abort, w_release, w_last, w_tx_acc, w_mosi;
   logic w_unused;
   logic [WIDTH-1:0] w_load, w_rx_nxt;

   mems_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
      .clk(clk), .rst(rst), .i_d(bus.sck), .o_q(w_sck_q), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
   );
   mems_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
      .clk(clk), .rst(rst), .i_d(bus.cs), .o_q(w_cs_q), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
   );
   assign w_unused = ^{w_sck_q, w_sck_rise, w_cs_q};

   // MOSI uses the same depth as SCK so the sampled bit lines up with the detected fall
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_mosi_sync <= '0;
      else      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.mosi};
   end
   assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

   assign w_last   = (r_ctr == CTR_W'(WIDTH - 1));
   assign w_tx_acc = bus.tx_valid & ~r_hold_full;
   assign w_load   = r_hold_full ? r_hold : IDLE_WORD;
   assign w_rx_nxt = {r_rx_sh[WIDTH-2:0], w_mosi};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= ST_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_shift     = 1'b0;
      w_done      = 1'b0;
      w_abort     = 1'b0;
      w_release   = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (w_cs_fall) begin
               w_start     = 1'b1;
               w_state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            // CS rise wins, but a coincident final fall still completes the word
            if (w_cs_rise) begin
               w_state_nxt = ST_IDLE;
               w_release   = 1'b1;
               if (w_sck_fall && w_last) begin
                  w_shift = 1'b1;
                  w_done  = 1'b1;
               end else begin
                  w_abort = 1'b1;
               end
            end else if (w_sck_fall) begin
               w_shift = 1'b1;
               if (w_last) begin
                  w_done      = 1'b1;
                  w_state_nxt = ST_WAIT_CS;
               end
            end
         end
         ST_WAIT_CS: begin
            if (w_cs_rise) begin
               w_release   = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hold      <= '0;
         r_hold_full <= 1'b0;
         r_tx_sh     <= '0;
         r_rx_sh     <= '0;
         r_rx_data   <= '0;
         r_ctr       <= '0;
         r_miso      <= 1'b0;
         r_miso_oe   <= 1'b0;
         r_rx_valid  <= 1'b0;
         r_frame_err <= 1'b0;
         r_underrun  <= 1'b0;
      end else begin
         r_rx_valid  <= 1'b0;
         r_frame_err <= 1'b0;
         r_underrun  <= 1'b0;
         // A word offered in the same cycle as an empty-register frame start waits for the next frame
         if (w_tx_acc) begin
            r_hold      <= bus.tx_data;
            r_hold_full <= 1'b1;
         end else if (w_start) begin
            r_hold_full <= 1'b0;
         end
         if (w_start) begin
            r_tx_sh    <= w_load;
            r_underrun <= ~r_hold_full;
            r_miso     <= w_load[WIDTH-1];
            r_miso_oe  <= 1'b1;
            r_ctr      <= '0;
         end
         if (w_shift) begin
            r_rx_sh <= w_rx_nxt;
            r_tx_sh <= {r_tx_sh[WIDTH-2:0], 1'b0};
            r_miso  <= r_tx_sh[WIDTH-2];
            r_ctr   <= r_ctr + 1'b1;
         end
         if (w_done) begin
            r_rx_data  <= w_rx_nxt;
            r_rx_valid <= 1'b1;
            r_miso     <= 1'b0;
         end
         if (w_release) begin
            r_miso    <= 1'b0;
            r_miso_oe <= 1'b0;
         end
         if (w_abort) r_frame_err <= 1'b1;
      end
   end

   assign bus.miso        = r_miso;
   assign bus.miso_oe     = r_miso_oe;
   assign bus.tx_ready    = ~r_hold_full;
   assign bus.rx_data     = r_rx_data;
   assign bus.rx_valid    = r_rx_valid;
   assign bus.busy        = (r_state != ST_IDLE);
   assign bus.frame_err   = r_frame_err;
   assign bus.tx_underrun = r_underrun;
endmodule
